// File: rtl/matrix_mem_pkg.sv
// ---------------------------------------------------------------------------
// matrix_mem_pkg
// Shared definitions for the banked matrix Memory block and its initiators:
// default address/data/dimension widths, the tile fetcher state encoding and
// the per-beat sideband tag carried alongside read data.
// ---------------------------------------------------------------------------
package matrix_mem_pkg;

  localparam int MEM_ADDR_W      = 16;  // memory word address width
  localparam int MEM_DATA_W      = 32;  // memory / stream data width
  localparam int MEM_DIM_W       = 8;   // tile rows / cols width
  localparam int TILE_FIFO_DEPTH = 4;   // fetcher output buffer entries

  typedef enum logic [1:0] {
    IDLE,   // waiting for start
    ISSUE,  // presenting read addresses
    DRAIN,  // all addresses issued, emptying the output buffer
    DONE    // single-cycle completion
  } fetch_state_t;

  // Stream markers computed when an address is issued; they travel with the
  // read through the memory latency and into the FIFO.
  typedef struct packed {
    logic row_last;
    logic last;
  } beat_tag_t;

endpackage

// File: rtl/tile_fetch_fifo.sv
// ---------------------------------------------------------------------------
// tile_fetch_fifo
// Synchronous show-ahead FIFO for the tile fetcher output stream. Writes are
// registered; the head entry is visible on rd_data_o whenever valid_o is high
// and is consumed by rd_en_i. The occupancy count feeds the fetcher's issue
// credit, which guarantees no write arrives while full.
//
// Ports:
//   clock, reset_n  clock / asynchronous active-low reset
//   wr_en_i         write strobe
//   wr_data_i       entry to write
//   rd_en_i         consumer accept (ignored when empty)
//   rd_data_o       head entry, zero when empty
//   valid_o         FIFO not empty
//   count_o         number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module tile_fetch_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_rd;

  assign valid_o = (count_q != '0);
  assign do_rd   = rd_en_i && valid_o;
  assign count_o = count_q;

  // Gate the head with valid so the stream payload reads zero when empty,
  // including straight out of reset.
  assign rd_data_o = valid_o ? store_q[rd_ptr_q] : '0;

  // NOTE: the storage array has no reset; only pointers and count do. Entries
  // are never observed before being written, and a reset storage array would
  // prevent mapping onto RAM/flop-array primitives.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      store_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Simultaneous read and write leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({wr_en_i, do_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_rd)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/matrix_tile_fetcher.sv
// ---------------------------------------------------------------------------
// matrix_tile_fetcher
// Read-side initiator for the banked matrix Memory. A start command latches a
// rectangular tile (rows x cols words, row stride) and walks it row-major
// through the memory's synchronous read port. Words are delivered as a
// valid/ready stream with row-end and tile-end markers. Address issue is
// gated by credit against the output FIFO so backpressure never drops a read.
//
// Ports:
//   clock, reset_n               clock / asynchronous active-low reset
//   start                        command strobe, honoured only in IDLE
//   base_addr, rows, cols, stride  tile description, latched on start
//   busy                         tile in progress (ISSUE or DRAIN)
//   done                         one-cycle completion pulse
//   mem_address, mem_wren        registered read address / write enable (0)
//   mem_q                        read data, one cycle after address sampling
//   out_data, out_valid, out_ready  output stream
//   out_row_last, out_last       last column of row / last word of tile
// ---------------------------------------------------------------------------
module matrix_tile_fetcher
  import matrix_mem_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int DIM_W      = MEM_DIM_W,
  parameter int FIFO_DEPTH = TILE_FIFO_DEPTH
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  rows,
  input  logic [DIM_W-1:0]  cols,
  input  logic [ADDR_W-1:0] stride,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_row_last,
  output logic              out_last
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W   = CNT_W + 1;          // fifo count + up to 2 in flight
  localparam int ENTRY_W = DATA_W + $bits(beat_tag_t);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [DIM_W-1:0]  col_q, col_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic [DIM_W-1:0]  rows_q, rows_d;
  logic [DIM_W-1:0]  cols_q, cols_d;
  logic [ADDR_W-1:0] stride_q, stride_d;

  // Read pipeline: stage 1 = address registered on mem_address, stage 2 =
  // mem_q valid and written into the FIFO at the next edge.
  logic              s1_valid_q, s1_valid_d;
  beat_tag_t         s1_tag_q, s1_tag_d;
  logic              s2_valid_q;
  beat_tag_t         s2_tag_q;

  logic [CNT_W-1:0]  fifo_count;
  logic [ENTRY_W-1:0] fifo_head;
  logic [OCC_W-1:0]  occupancy;
  logic              credit_ok;
  logic              fifo_valid;
  logic              final_hs;

  // Next walk position, derived from the position currently on mem_address.
  logic              row_end;
  logic [DIM_W-1:0]  nxt_col, nxt_row;
  logic [ADDR_W-1:0] nxt_base;

  // Reads already issued but not yet in the FIFO still need a slot.
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(s1_valid_q) + OCC_W'(s2_valid_q);
  assign credit_ok = (occupancy < OCC_W'(FIFO_DEPTH));

  assign row_end  = (col_q == cols_q - DIM_W'(1));
  assign nxt_col  = row_end ? '0 : col_q + DIM_W'(1);
  assign nxt_row  = row_end ? row_q + DIM_W'(1) : row_q;
  assign nxt_base = row_end ? row_base_q + stride_q : row_base_q;

  assign final_hs = fifo_valid && out_ready && out_last;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    row_base_d = row_base_q;
    col_d      = col_q;
    row_d      = row_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    stride_d   = stride_q;
    s1_valid_d = 1'b0;
    s1_tag_d   = s1_tag_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          rows_d   = rows;
          cols_d   = cols;
          stride_d = stride;
          if (rows == '0 || cols == '0) begin
            state_d = DONE;
          end else begin
            // The first address issues on the accepting edge; the FIFO is
            // empty and nothing is in flight, so credit is always available.
            addr_d            = base_addr;
            row_base_d        = base_addr;
            col_d             = '0;
            row_d             = '0;
            s1_valid_d        = 1'b1;
            s1_tag_d.row_last = (cols == DIM_W'(1));
            s1_tag_d.last     = (cols == DIM_W'(1)) && (rows == DIM_W'(1));
            state_d           = s1_tag_d.last ? DRAIN : ISSUE;
          end
        end
      end

      ISSUE: begin
        if (credit_ok) begin
          addr_d            = nxt_base + ADDR_W'(nxt_col);
          row_base_d        = nxt_base;
          col_d             = nxt_col;
          row_d             = nxt_row;
          s1_valid_d        = 1'b1;
          s1_tag_d.row_last = (nxt_col == cols_q - DIM_W'(1));
          s1_tag_d.last     = s1_tag_d.row_last && (nxt_row == rows_q - DIM_W'(1));
          if (s1_tag_d.last) state_d = DRAIN;
        end
      end

      DRAIN: begin
        if (final_hs) state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      row_base_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      rows_q     <= '0;
      cols_q     <= '0;
      stride_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_tag_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      row_base_q <= row_base_d;
      col_q      <= col_d;
      row_q      <= row_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      stride_q   <= stride_d;
      s1_valid_q <= s1_valid_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s1_valid_q;
      s2_tag_q   <= s1_tag_q;
    end
  end

  tile_fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_en_i   (s2_valid_q),
    .wr_data_i ({s2_tag_q, mem_q}),
    .rd_en_i   (out_ready),
    .rd_data_o (fifo_head),
    .valid_o   (fifo_valid),
    .count_o   (fifo_count)
  );

  assign out_valid    = fifo_valid;
  assign out_data     = fifo_head[DATA_W-1:0];
  assign out_last     = fifo_head[DATA_W];
  assign out_row_last = fifo_head[DATA_W+1];

  assign busy        = (state_q == ISSUE) || (state_q == DRAIN);
  assign done        = (state_q == DONE);
  assign mem_address = addr_q;
  assign mem_wren    = 1'b0;

endmodule

// File: tb/tb_matrix_tile_fetcher.sv
// ---------------------------------------------------------------------------
// tb_matrix_tile_fetcher
// Directed bench for matrix_tile_fetcher with a behavioural synchronous-read
// memory. Stimulus pushes expected beats into a scoreboard queue; a monitor
// pops and compares on every stream handshake.
// ---------------------------------------------------------------------------
module tb_matrix_tile_fetcher;

  typedef struct {
    logic [31:0] data;
    logic        row_last;
    logic        last;
  } beat_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] base_addr;
  logic [7:0]  rows, cols;
  logic [15:0] stride;
  logic        busy, done;
  logic [15:0] mem_address;
  logic        mem_wren;
  logic [31:0] mem_q = '0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_row_last, out_last;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int beats_seen   = 0;
  int last_hs_edge = -1;
  beat_t sb_q[$];

  matrix_tile_fetcher dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .base_addr    (base_addr),
    .rows         (rows),
    .cols         (cols),
    .stride       (stride),
    .busy         (busy),
    .done         (done),
    .mem_address  (mem_address),
    .mem_wren     (mem_wren),
    .mem_q        (mem_q),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_row_last (out_row_last),
    .out_last     (out_last)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {~a, a};
  endfunction

  // Synchronous-read memory: samples the address at the edge, data valid after.
  always @(posedge clock) mem_q <= mem_word(mem_address);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected beats from the closed-form address base + r*stride + c.
  task automatic push_tile(input logic [15:0] base, input int nr, input int nc,
                           input logic [15:0] strd);
    for (int r = 0; r < nr; r++) begin
      for (int c = 0; c < nc; c++) begin
        logic [15:0] a;
        beat_t b;
        a = base + 16'(r) * strd + 16'(c);
        b.data     = mem_word(a);
        b.row_last = (c == nc - 1);
        b.last     = (c == nc - 1) && (r == nr - 1);
        sb_q.push_back(b);
      end
    end
  endtask

  // Monitor: a beat sampled valid&ready at the negedge completes at the next edge.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      beats_seen++;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat actual=%0h required=none", out_data);
      end else begin
        beat_t e;
        e = sb_q.pop_front();
        check("beat_data", 64'(out_data), 64'(e.data));
        check("beat_row_last", 64'(out_row_last), 64'(e.row_last));
        check("beat_last", 64'(out_last), 64'(e.last));
        if (out_last) last_hs_edge = cyc + 1;
      end
    end
  end

  task automatic do_start(input logic [15:0] b, input logic [7:0] nr, input logic [7:0] nc,
                          input logic [15:0] s);
    @(posedge clock); #1;
    base_addr = b; rows = nr; cols = nc; stride = s; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (done) begin
        dcyc = cyc;
        break;
      end
    end
    check(name, 64'(dcyc >= 0), 64'd1);
  endtask

  logic [15:0] exp_a1 [6] = '{16'h0010, 16'h0011, 16'h0012, 16'h0018, 16'h0019, 16'h001A};
  logic [15:0] exp_a3 [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dc;
    reset_n = 1'b0; start = 1'b0; base_addr = '0; rows = '0; cols = '0;
    stride = '0; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_row_last", 64'(out_row_last), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_mem_address", 64'(mem_address), 64'd0);
    check("rst_mem_wren", 64'(mem_wren), 64'd0);
    reset_n = 1'b1;

    // 1: 2x3 tile, stride 8, no backpressure.
    push_tile(16'h0010, 2, 3, 16'd8);
    do_start(16'h0010, 8'd2, 8'd3, 16'd8);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("t1_addr", 64'(mem_address), 64'(exp_a1[i]));
      if (i == 0) check("t1_busy", 64'(busy), 64'd1);
      if (i == 1) check("t1_no_early_valid", 64'(out_valid), 64'd0);
      if (i == 2) check("t1_first_valid", 64'(out_valid), 64'd1);
      if (i == 3) check("t1_mem_wren", 64'(mem_wren), 64'd0);
    end
    wait_done("t1_done_seen", dc);
    check("t1_done_timing", 64'(dc), 64'(last_hs_edge));
    check("t1_busy_at_done", 64'(busy), 64'd0);
    check("t1_sb_empty", 64'(sb_q.size()), 64'd0);

    // 2: same tile with consumer stalled; issue stops after 4 words.
    out_ready = 1'b0;
    push_tile(16'h0010, 2, 3, 16'd8);
    do_start(16'h0010, 8'd2, 8'd3, 16'd8);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (i == 8) begin
        check("t2_addr_stalled", 64'(mem_address), 64'h0018);
        check("t2_valid_held", 64'(out_valid), 64'd1);
        check("t2_busy", 64'(busy), 64'd1);
      end
    end
    @(posedge clock); #1;
    out_ready = 1'b1;
    wait_done("t2_done_seen", dc);
    check("t2_sb_empty", 64'(sb_q.size()), 64'd0);

    // 3: address wrap-around.
    push_tile(16'hFFFE, 1, 4, 16'd0);
    do_start(16'hFFFE, 8'd1, 8'd4, 16'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("t3_addr", 64'(mem_address), 64'(exp_a3[i]));
    end
    wait_done("t3_done_seen", dc);
    check("t3_sb_empty", 64'(sb_q.size()), 64'd0);

    // 4: zero-row tile: done next cycle, no reads, no beats.
    do_start(16'h0500, 8'd0, 8'd5, 16'd1);
    @(negedge clock);
    check("t4_done", 64'(done), 64'd1);
    check("t4_addr_held", 64'(mem_address), 64'h0001);
    check("t4_no_valid", 64'(out_valid), 64'd0);
    @(negedge clock);
    check("t4_done_pulse", 64'(done), 64'd0);
    check("t4_no_valid2", 64'(out_valid), 64'd0);

    // 5: start while busy is ignored.
    push_tile(16'h0100, 2, 2, 16'h0010);
    do_start(16'h0100, 8'd2, 8'd2, 16'h0010);
    @(posedge clock); #1;
    base_addr = 16'h0200; rows = 8'd3; cols = 8'd3; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("t5_busy", 64'(busy), 64'd1);
    wait_done("t5_done_seen", dc);
    check("t5_final_addr", 64'(mem_address), 64'h0111);
    repeat (4) @(negedge clock);
    check("t5_no_restart", 64'(busy), 64'd0);
    check("t5_sb_empty", 64'(sb_q.size()), 64'd0);

    // 6: reset mid-tile after two beats, then refetch the full tile.
    push_tile(16'h0040, 4, 4, 16'h0020);
    begin
      int target;
      target = beats_seen + 2;
      do_start(16'h0040, 8'd4, 8'd4, 16'h0020);
      for (int i = 0; i < 100 && beats_seen < target; i++) @(negedge clock);
      check("t6_beats_before_reset", 64'(beats_seen), 64'(target));
    end
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_data", 64'(out_data), 64'd0);
    check("t6_rst_addr", 64'(mem_address), 64'd0);
    check("t6_rst_tags", 64'({out_row_last, out_last}), 64'd0);
    sb_q.delete();
    repeat (2) @(negedge clock);
    check("t6_rst_no_done", 64'(done), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check("t6_idle_no_done", 64'(done), 64'd0);
    check("t6_idle_busy", 64'(busy), 64'd0);
    push_tile(16'h0040, 4, 4, 16'h0020);
    do_start(16'h0040, 8'd4, 8'd4, 16'h0020);
    wait_done("t6_done_seen", dc);
    check("t6_sb_empty", 64'(sb_q.size()), 64'd0);

    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
